// File: rtl/la_spregfile_ctrl.sv
//------------------------------------------------------------------------------
// la_spregfile_ctrl
//
// Request/response front-end for la_spregfile. A valid/ready request stream
// (read or bit-masked write) becomes single-cycle ce/we strobes on the memory
// port. Read data comes back from the memory one cycle after the strobe and is
// captured into a small response FIFO. This lets the consumer apply
// backpressure on the response side without losing data.
//
// Reads are only accepted when a FIFO slot is guaranteed for them. The check
// counts stored entries, plus the read whose data is still in flight, minus
// any entry leaving this cycle. Therefore mem_dout is never dropped. Writes
// never wait on the FIFO.
//
// Parameters:
//   DW    - data width (must match la_spregfile)
//   AW    - address width (must match la_spregfile)
//   DEPTH - response FIFO entries, 2..16
//   CW    - occupancy counter width, 2**CW > DEPTH
//
// Ports:
//   clk, reset           - single clock, synchronous active-high reset
//   req_valid/req_ready  - request handshake
//   req_we               - 1 = write, 0 = read
//   req_addr/din/wmask   - request address, write data, per-bit write mask
//   rsp_valid/rsp_ready  - response handshake
//   rsp_dout             - read data, returned in request order
//   mem_ce/we/wmask/addr/din - drive la_spregfile
//   mem_dout             - la_spregfile read data, valid the cycle after a read
//   busy                 - a read is in flight or the FIFO holds data
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module la_spregfile_ctrl #(
    parameter int DW    = 32,
    parameter int AW    = 10,
    parameter int DEPTH = 2,
    parameter int CW    = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_din,
    input  logic [DW-1:0] req_wmask,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_dout,
    output logic          mem_ce,
    output logic          mem_we,
    output logic [DW-1:0] mem_wmask,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    // Pointer width. DEPTH >= 2 always gives at least one bit.
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    //--------------------------------------------------------------------------
    // State
    //--------------------------------------------------------------------------
    logic          reset_q;   // high during reset and for one cycle after release
    logic          inflight;  // read strobed last cycle; mem_dout is valid now
    logic [CW-1:0] count;     // entries held in the response FIFO
    logic [PW-1:0] head;      // next entry to return
    logic [PW-1:0] tail;      // next slot to fill
    logic [DW-1:0] fifo_mem [DEPTH];

    //--------------------------------------------------------------------------
    // Handshake and admission control
    //--------------------------------------------------------------------------
    logic          acc;
    logic          push;
    logic          pop;
    logic          read_ok;
    logic [CW:0]   occupancy;

    // Circular pointer advance. This also wraps correctly for a
    // non-power-of-two DEPTH.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign rsp_valid = (count != '0);
    assign pop       = rsp_valid & rsp_ready;
    assign push      = inflight;

    // NOTE: every signal assigned in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        occupancy = '0;
        read_ok   = 1'b0;
        // Slots committed after this edge, not counting a new read.
        // An entry leaving this cycle frees its slot at once. That gives the
        // intended rsp_ready -> req_ready combinational path.
        // count + inflight >= pop always holds, so this cannot underflow.
        occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        read_ok   = (occupancy < (CW+1)'(DEPTH));
    end

    // ~reset holds req_ready low in the reset cycle itself. This covers the
    // very first cycle, before reset_q has been loaded.
    assign req_ready = ~reset & ~reset_q & (req_we | read_ok);
    assign acc       = req_valid & req_ready;

    //--------------------------------------------------------------------------
    // Memory port: strobes follow the handshake, payload passes straight through
    //--------------------------------------------------------------------------
    assign mem_ce    = acc;
    assign mem_we    = acc & req_we;
    assign mem_addr  = req_addr;
    assign mem_din   = req_din;
    assign mem_wmask = req_wmask;

    assign busy      = inflight | rsp_valid;

    //--------------------------------------------------------------------------
    // Control state
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All registers then
    // update together at the edge, whatever order the statements are in.
    always_ff @(posedge clk) begin
        if (reset) begin
            reset_q  <= 1'b1;
            inflight <= 1'b0;   // a read in flight at reset is dropped
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            reset_q  <= 1'b0;
            inflight <= acc & ~req_we;
            if (push) begin
                tail <= ptr_inc(tail);
            end
            if (pop) begin
                head <= ptr_inc(head);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    //--------------------------------------------------------------------------
    // Response storage
    //--------------------------------------------------------------------------
    // NOTE: the data array has no reset. Its contents are never observed
    // while count is zero, so clearing it would only cost reset routing.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_mem[tail] <= mem_dout;
        end
    end

    // Registered head entry. There is no combinational path from mem_dout.
    assign rsp_dout = fifo_mem[head];

    //--------------------------------------------------------------------------
    // Admission control must never let a push land on a full FIFO.
    //--------------------------------------------------------------------------
    a_no_push_when_full: assert property (
        @(posedge clk) disable iff (reset) !(push && (count == CW'(DEPTH)))
    );

endmodule

// File: tb/tb_la_spregfile_ctrl.sv
//------------------------------------------------------------------------------
// tb_la_spregfile_ctrl
//
// The bench runs two controller instances: DEPTH=2 and DEPTH=3. One shared
// la_spregfile behavioural stub serves whichever instance is selected; the
// other instance sees no traffic.
//
// The reference model tracks every accepted read as (data, accept cycle) in
// one queue:
//   - data is the value of a reference memory at acceptance time;
//   - a response is available two cycles after acceptance;
//   - the number of outstanding reads bounds admission.
// Each negedge compares all DUT outputs against this model. Directed
// scenarios add literal expectations on the returned data and timing.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_la_spregfile_ctrl;

    localparam int DW = 32;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_din = '0;
    logic [DW-1:0] req_wmask = '0;
    logic          rsp_ready = 1'b0;
    logic          sel = 1'b0;          // 0: DEPTH=2 instance, 1: DEPTH=3 instance
    logic          rand_rr = 1'b0;

    logic [1:0]    req_ready_v, rsp_valid_v, busy_v, mem_ce_v, mem_we_v;
    logic [DW-1:0] rsp_dout_v [2];
    logic [DW-1:0] mem_wmask_v [2];
    logic [DW-1:0] mem_din_v [2];
    logic [AW-1:0] mem_addr_v [2];
    logic [DW-1:0] mem_dout = '0;

    always #5 clk = ~clk;

    la_spregfile_ctrl #(.DW(DW), .AW(AW), .DEPTH(2), .CW(5)) u_dut2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & ~sel), .req_ready(req_ready_v[0]),
        .req_we(req_we), .req_addr(req_addr), .req_din(req_din), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready & ~sel), .rsp_dout(rsp_dout_v[0]),
        .mem_ce(mem_ce_v[0]), .mem_we(mem_we_v[0]), .mem_wmask(mem_wmask_v[0]),
        .mem_addr(mem_addr_v[0]), .mem_din(mem_din_v[0]), .mem_dout(mem_dout),
        .busy(busy_v[0])
    );

    la_spregfile_ctrl #(.DW(DW), .AW(AW), .DEPTH(3), .CW(5)) u_dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid & sel), .req_ready(req_ready_v[1]),
        .req_we(req_we), .req_addr(req_addr), .req_din(req_din), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready & sel), .rsp_dout(rsp_dout_v[1]),
        .mem_ce(mem_ce_v[1]), .mem_we(mem_we_v[1]), .mem_wmask(mem_wmask_v[1]),
        .mem_addr(mem_addr_v[1]), .mem_din(mem_din_v[1]), .mem_dout(mem_dout),
        .busy(busy_v[1])
    );

    // Outputs of the selected instance
    logic          cur_ready, cur_valid, cur_busy, cur_ce, cur_we;
    logic [DW-1:0] cur_dout, cur_wmask, cur_din;
    logic [AW-1:0] cur_addr;
    assign cur_ready = req_ready_v[sel];
    assign cur_valid = rsp_valid_v[sel];
    assign cur_busy  = busy_v[sel];
    assign cur_ce    = mem_ce_v[sel];
    assign cur_we    = mem_we_v[sel];
    assign cur_dout  = rsp_dout_v[sel];
    assign cur_wmask = mem_wmask_v[sel];
    assign cur_din   = mem_din_v[sel];
    assign cur_addr  = mem_addr_v[sel];

    // la_spregfile stub: registered read, masked write, write-then-read order
    logic [DW-1:0] sram [1024] = '{default: '0};
    always @(posedge clk) begin
        if (cur_ce) begin
            if (cur_we) sram[cur_addr] <= (sram[cur_addr] & ~cur_wmask) | (cur_din & cur_wmask);
            else        mem_dout <= sram[cur_addr];
        end
    end

    //--------------------------------------------------------------------------
    // Reference model
    //--------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        int            t;
    } rd_t;

    rd_t           q[$];      // accepted, not yet consumed reads
    rd_t           got[$];    // responses actually consumed from the DUT
    logic [DW-1:0] ref_mem [1024] = '{default: '0};
    int            cyc = 0;
    bit            rst_q_m = 1'b1;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit m_valid();
        return (q.size() > 0) && (q[0].t <= cyc - 2);
    endfunction

    function automatic bit m_ready();
        int occ;
        if (reset || rst_q_m) return 1'b0;
        occ = q.size() - ((m_valid() && rsp_ready) ? 1 : 0);
        return req_we || (occ < (sel ? 3 : 2));
    endfunction

    always @(posedge clk) begin : model_update
        bit acc;
        bit pop;
        acc = req_valid && m_ready();
        pop = m_valid() && rsp_ready;
        if (reset) begin
            q.delete();
            rst_q_m = 1'b1;
        end else begin
            rst_q_m = 1'b0;
            if (pop) void'(q.pop_front());
            if (acc) begin
                if (req_we) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_din & req_wmask);
                else        q.push_back('{ref_mem[req_addr], cyc});
            end
        end
        cyc++;
    end

    always @(negedge clk) begin : compare
        bit er;
        bit ece;
        er  = m_ready();
        ece = req_valid && er;
        check("req_ready", cur_ready, er);
        check("mem_ce", cur_ce, ece);
        check("mem_we", cur_we, ece && req_we);
        if (ece) begin
            check("mem_addr", cur_addr, req_addr);
            check("mem_din", cur_din, req_din);
            check("mem_wmask", cur_wmask, req_wmask);
        end
        if (!reset) begin
            check("rsp_valid", cur_valid, m_valid());
            check("busy", cur_busy, q.size() > 0);
            if (m_valid()) check("rsp_dout", cur_dout, q[0].data);
            if (sel) check("depth3_count_bound", u_dut3.count <= 5'd3, 1'b1);
            if (cur_valid && rsp_ready) got.push_back('{cur_dout, cyc});
        end
    end

    //--------------------------------------------------------------------------
    // Stimulus helpers
    //--------------------------------------------------------------------------
    // Present one request until accepted. Reports the cycles waited and the
    // acceptance cycle.
    task automatic send(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] m, output int waited, output int t_acc);
        bit done;
        done   = 1'b0;
        waited = 0;
        t_acc  = -1;
        req_valid = 1'b1; req_we = we; req_addr = a; req_din = d; req_wmask = m;
        while (!done && waited < 200) begin
            @(negedge clk);
            done = cur_ready;
            if (done) t_acc = cyc;
            @(posedge clk); #1;
            waited++;
        end
        req_valid = 1'b0;
        check("send_accepted", done, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        while ((cur_busy || q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_idle", cur_busy, 1'b0);
    endtask

    initial begin : rand_ready
        forever begin
            @(posedge clk); #1;
            if (rand_rr) rsp_ready = 1'($urandom_range(1, 0));
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    //--------------------------------------------------------------------------
    // Directed scenarios
    //--------------------------------------------------------------------------
    initial begin : main
        int n, t, tw, base, nreads;
        int tacc [5];
        bit we;

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        req_valid = 1'b1;             // a read is waiting, but must not be taken yet
        @(negedge clk);
        check("post_release_ready", cur_ready, 1'b0);
        check("post_release_valid", cur_valid, 1'b0);
        check("post_release_busy", cur_busy, 1'b0);
        @(posedge clk); #1;
        req_valid = 1'b0;

        // 1: five writes, five back-to-back reads, two-cycle latency
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(1'b1, AW'(i), DW'(32'hA0 + i), '1, n, t);
            check("t1_write_no_wait", n, 1);
        end
        base = got.size();
        for (int i = 0; i < 5; i++) begin
            send(1'b0, AW'(i), '0, '0, n, t);
            tacc[i] = t;
            check("t1_read_no_wait", n, 1);
        end
        drain();
        check("t1_resp_count", got.size() - base, 5);
        if (got.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                check("t1_data", got[base + i].data, DW'(32'hA0 + i));
                check("t1_latency", got[base + i].t - tacc[i], 2);
            end
        end

        // 2: backpressure with DEPTH=2
        rsp_ready = 1'b0;
        base = got.size();
        send(1'b0, 10'd0, '0, '0, n, t);
        check("t2_read0_no_wait", n, 1);
        send(1'b0, 10'd1, '0, '0, n, t);
        check("t2_read1_no_wait", n, 1);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd2;
        repeat (3) begin
            @(negedge clk);
            check("t2_read_stalled", cur_ready, 1'b0);
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        send(1'b1, 10'd10, 32'h55, '1, n, t);
        check("t2_write_during_stall", n, 1);
        rsp_ready = 1'b1;
        send(1'b0, 10'd2, '0, '0, n, t);
        check("t2_resume_on_first_pop", n, 1);
        drain();
        check("t2_resp_count", got.size() - base, 3);
        if (got.size() >= base + 3) begin
            check("t2_data0", got[base].data, 32'hA0);
            check("t2_data1", got[base + 1].data, 32'hA1);
            check("t2_data2", got[base + 2].data, 32'hA2);
        end

        // 3: masked write merges with old contents
        send(1'b1, 10'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n, t);
        send(1'b1, 10'd7, 32'h0000_0000, 32'h0000_FFFF, n, t);
        base = got.size();
        send(1'b0, 10'd7, '0, '0, n, t);
        drain();
        check("t3_resp_count", got.size() - base, 1);
        if (got.size() > base) check("t3_masked_data", got[base].data, 32'hFFFF_0000);

        // 4: read directly behind a write to the same address
        send(1'b1, 10'd3, 32'h1234_5678, '1, n, tw);
        base = got.size();
        send(1'b0, 10'd3, '0, '0, n, t);
        check("t4_read_next_cycle", t - tw, 1);
        drain();
        check("t4_resp_count", got.size() - base, 1);
        if (got.size() > base) begin
            check("t4_data", got[base].data, 32'h1234_5678);
            check("t4_write_to_rsp", got[base].t - tw, 3);
        end

        // 5: mixed traffic, random backpressure, DEPTH=3
        sel = 1'b1;
        base = got.size();
        nreads = 0;
        rand_rr = 1'b1;
        for (int i = 0; i < 200; i++) begin
            we = 1'($urandom_range(1, 0));
            send(we, AW'($urandom_range(7, 0)), $urandom,
                 ($urandom_range(1, 0) != 0) ? 32'hFFFF_FFFF : $urandom, n, t);
            if (!we) nreads++;
        end
        rand_rr = 1'b0;
        drain();
        check("t5_resp_count", got.size() - base, nreads);
        sel = 1'b0;

        // 6: reset lands while a read is in flight
        send(1'b1, 10'd100, 32'hC0FF_EE00, '1, n, t);
        rsp_ready = 1'b1;
        send(1'b0, 10'd100, '0, '0, n, t);   // now in the cycle after acceptance
        reset = 1'b1;
        base = got.size();
        @(negedge clk);
        check("t6_ready_in_reset", cur_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 10'd100;
        @(negedge clk);
        check("t6_valid_after_reset", cur_valid, 1'b0);
        check("t6_busy_after_reset", cur_busy, 1'b0);
        check("t6_ready_after_release", cur_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t6_ready_resumes", cur_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        drain();
        check("t6_resp_count", got.size() - base, 1);
        if (got.size() > base) check("t6_data", got[base].data, 32'hC0FF_EE00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
